// File: rtl/clk_mmcm_core_if.sv
// Output bundle of the fabric clock-enable generator: lock status, downstream reset
// and the divided-clock / fractional-rate strobes.
interface clk_mmcm_core_if;
   logic locked;
   logic rst_out;
   logic clk_25;
   logic ce_25;
   logic ce_frac;

   modport master (output locked, rst_out, clk_25, ce_25, ce_frac);
   modport slave  (input  locked, rst_out, clk_25, ce_25, ce_frac);
endinterface

// File: rtl/clk_mmcm_core.sv
// Lock sequencer plus /DIV square wave and exact NUM/DEN fractional strobe, all held
// quiet until the lock interval elapses after a synchronous reset.
module clk_mmcm_core #(
   parameter int DIV         = 4,
   parameter int LOCK_CYCLES = 1024,
   // 27/50 of the 100 MHz board clock gives an exact 54 MHz average strobe rate
   parameter int FRAC_NUM    = 27,
   parameter int FRAC_DEN    = 50
) (
   input  logic            clk,
   input  logic            reset,
   clk_mmcm_core_if.master out_if
);
   localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   localparam int DCW = $clog2(DIV);
   localparam int AW  = $clog2(FRAC_DEN) + 1;

   localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);
   localparam logic [DCW-1:0] DIV_HALF  = DCW'(DIV / 2 - 1);
   localparam logic [DCW-1:0] DIV_LAST  = DCW'(DIV - 1);
   localparam logic [AW-1:0]  NUM_W     = AW'(FRAC_NUM);
   localparam logic [AW-1:0]  DEN_W     = AW'(FRAC_DEN);

   generate
      if (DIV < 2 || (DIV % 2) != 0) begin : g_bad_div
         $error("clk_mmcm_core: DIV must be even and >= 2");
      end
      if (LOCK_CYCLES < 1) begin : g_bad_lock
         $error("clk_mmcm_core: LOCK_CYCLES must be >= 1");
      end
      if (FRAC_DEN < 1 || FRAC_NUM < 0 || FRAC_NUM > FRAC_DEN) begin : g_bad_frac
         $error("clk_mmcm_core: need FRAC_DEN >= 1 and 0 <= FRAC_NUM <= FRAC_DEN");
      end
   endgenerate

   logic [LCW-1:0] r_lock_cnt;
   logic           r_locked;
   logic           r_rst_out;
   logic [DCW-1:0] r_div_cnt;
   logic           r_clk_25;
   logic           r_ce_25;
   logic [AW-1:0]  r_acc;
   logic           r_ce_frac;

   logic [AW-1:0]  w_sum;
   logic           w_wrap;
   logic           w_div_half;
   logic           w_div_last;

   // acc < DEN and NUM <= DEN, so the sum always fits in AW bits
   assign w_sum      = r_acc + NUM_W;
   assign w_wrap     = (w_sum >= DEN_W);
   assign w_div_half = (r_div_cnt == DIV_HALF);
   assign w_div_last = (r_div_cnt == DIV_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_lock_cnt <= '0;
         r_locked   <= 1'b0;
         r_rst_out  <= 1'b1;
      end else begin
         r_rst_out <= !r_locked;
         if (!r_locked) begin
            r_lock_cnt <= r_lock_cnt + 1'b1;
            r_locked   <= (r_lock_cnt == LOCK_LAST);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_div_cnt <= '0;
         r_clk_25  <= 1'b0;
         r_ce_25   <= 1'b0;
      end else if (r_locked) begin
         r_div_cnt <= w_div_last ? '0 : r_div_cnt + 1'b1;
         r_clk_25  <= r_clk_25 ^ (w_div_half | w_div_last);
         r_ce_25   <= w_div_half;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc     <= '0;
         r_ce_frac <= 1'b0;
      end else if (r_locked) begin
         r_acc     <= w_wrap ? (w_sum - DEN_W) : w_sum;
         r_ce_frac <= w_wrap;
      end
   end

   assign out_if.locked  = r_locked;
   assign out_if.rst_out = r_rst_out;
   assign out_if.clk_25  = r_clk_25;
   assign out_if.ce_25   = r_ce_25;
   assign out_if.ce_frac = r_ce_frac;
endmodule

// File: tb/tb_clk_mmcm_core.sv
// Directed bench for clk_mmcm_core: lock timing, divider pattern, NCO pulse density,
// mid-run reset repeatability and held reset, across three parameter sets.
module tb_clk_mmcm_core;
   localparam int LOCK      = 16;
   localparam int DIV_A     = 4;
   localparam int NUM_A     = 27;
   localparam int DEN_A     = 50;
   localparam int DIV_B     = 6;
   localparam int DEN_C     = 8;
   localparam int TRACE_LEN = 150;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   clk_mmcm_core_if if_a ();
   clk_mmcm_core_if if_b ();
   clk_mmcm_core_if if_c ();

   clk_mmcm_core #(.DIV(DIV_A), .LOCK_CYCLES(LOCK), .FRAC_NUM(NUM_A), .FRAC_DEN(DEN_A)) dut_a (
      .clk(clk), .reset(reset), .out_if(if_a)
   );
   clk_mmcm_core #(.DIV(DIV_B), .LOCK_CYCLES(LOCK), .FRAC_NUM(0), .FRAC_DEN(DEN_C)) dut_b (
      .clk(clk), .reset(reset), .out_if(if_b)
   );
   clk_mmcm_core #(.DIV(DIV_A), .LOCK_CYCLES(LOCK), .FRAC_NUM(DEN_C), .FRAC_DEN(DEN_C)) dut_c (
      .clk(clk), .reset(reset), .out_if(if_c)
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic [4:0] trace_a [TRACE_LEN];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Expected outputs after m edges in which locked was already high
   function automatic int exp_clk(input int m, input int div);
      return ((m % div) >= (div / 2)) ? 1 : 0;
   endfunction
   function automatic int exp_ce(input int m, input int div);
      return ((m % div) == (div / 2)) ? 1 : 0;
   endfunction
   function automatic int exp_frac(input int m, input int num, input int den);
      if (m < 1) return 0;
      return ((m * num) / den) - (((m - 1) * num) / den);
   endfunction

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_a_locked"},  if_a.locked,  0);
      check_eq({tag, "_a_rst_out"}, if_a.rst_out, 1);
      check_eq({tag, "_a_clk_25"},  if_a.clk_25,  0);
      check_eq({tag, "_a_ce_25"},   if_a.ce_25,   0);
      check_eq({tag, "_a_ce_frac"}, if_a.ce_frac, 0);
      check_eq({tag, "_a_acc"},     dut_a.r_acc,  0);
      check_eq({tag, "_b_locked"},  if_b.locked,  0);
      check_eq({tag, "_b_clk_25"},  if_b.clk_25,  0);
      check_eq({tag, "_c_ce_frac"}, if_c.ce_frac, 0);
   endtask

   // Runs `cycles` edges after reset release, checking every output against the model
   task automatic run_phase(input string name, input int cycles, input bit record, input bit compare);
      int m;
      int win_cnt;
      int f0;
      logic [4:0] v;
      win_cnt = 0;
      f0 = n_fail;
      for (int n = 1; n <= cycles; n++) begin
         @(posedge clk);
         #1;
         m = (n > LOCK) ? n - LOCK : 0;
         check_eq("a_locked",  if_a.locked,  (n >= LOCK) ? 1 : 0);
         check_eq("a_rst_out", if_a.rst_out, (n <= LOCK) ? 1 : 0);
         check_eq("a_clk_25",  if_a.clk_25,  exp_clk(m, DIV_A));
         check_eq("a_ce_25",   if_a.ce_25,   exp_ce(m, DIV_A));
         check_eq("a_ce_frac", if_a.ce_frac, exp_frac(m, NUM_A, DEN_A));
         check_eq("a_acc_lt_den", (dut_a.r_acc < DEN_A) ? 1 : 0, 1);
         check_eq("b_clk_25",  if_b.clk_25,  exp_clk(m, DIV_B));
         check_eq("b_ce_25",   if_b.ce_25,   exp_ce(m, DIV_B));
         check_eq("b_ce_frac", if_b.ce_frac, 0);
         check_eq("c_ce_frac", if_c.ce_frac, (m >= 1) ? 1 : 0);
         v = {if_a.locked, if_a.rst_out, if_a.clk_25, if_a.ce_25, if_a.ce_frac};
         if (record && n <= TRACE_LEN) trace_a[n-1] = v;
         if (compare && n <= TRACE_LEN) check_eq("a_repeat_trace", v, trace_a[n-1]);
         if (m >= 1) begin
            win_cnt += int'(if_a.ce_frac);
            if ((m % DEN_A) == 0) begin
               check_eq("a_frac_window", win_cnt, NUM_A);
               win_cnt = 0;
            end
         end
      end
      $display("phase %s: %0d cycles, new failures %0d", name, cycles, n_fail - f0);
   endtask

   initial begin
      int cut;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_state("init");
      $display("phase init reset: checked");

      reset = 1'b0;
      run_phase("lock_div_nco", LOCK + 10 * DEN_A + 20, 1'b1, 1'b0);

      // Restart from reset at a random point and expect an identical sequence
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_reset_state("restart");
      reset = 1'b0;
      cut = int'($urandom_range(LOCK + 60, LOCK + 3));
      run_phase("pre_cut", cut, 1'b0, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_reset_state("cut");
      $display("phase cut reset after %0d cycles: checked", cut);
      reset = 1'b0;
      run_phase("after_cut", TRACE_LEN, 1'b0, 1'b1);

      reset = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         check_reset_state("hold");
      end
      $display("phase reset_hold: 100 cycles");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
